// File: rtl/column_slice_scheduler_pkg.sv
// Shared raycaster constants and scheduler state encoding.
// Imported by the column slice scheduler, its interface and sub-module.
package raycast_pkg;

   localparam int NUM_COLUMNS = 160;
   localparam int HEIGHT_W    = 7;
   localparam int COORD_W     = 13;
   localparam int ANGLE_W     = 10;
   localparam int COL_W       = 8;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_CALC,
      PUSH,
      DONE
   } sched_state_t;

endpackage

// File: rtl/column_slice_scheduler_if.sv
// Calculator request/response and drawer valid/ready bundle.
// master = scheduler side, slave = calculator/drawer side.
interface column_slice_scheduler_if
   import raycast_pkg::COORD_W, raycast_pkg::ANGLE_W, raycast_pkg::COL_W;
#(
   parameter int HEIGHT_W = raycast_pkg::HEIGHT_W
);

   logic signed [COORD_W-1:0]  calc_playerX;
   logic signed [COORD_W-1:0]  calc_playerY;
   logic signed [ANGLE_W-1:0]  calc_angle_X;
   logic signed [ANGLE_W-1:0]  calc_angle_Y;
   logic        [COL_W-1:0]    calc_column;
   logic                       calc_begin;
   logic                       calc_end;
   logic        [HEIGHT_W-1:0] calc_slice_size;
   logic                       slice_valid;
   logic        [COL_W-1:0]    slice_column;
   logic        [HEIGHT_W-1:0] slice_height;
   logic                       slice_ready;

   modport master (
      output calc_playerX, calc_playerY,
      output calc_angle_X, calc_angle_Y,
      output calc_column, calc_begin,
      input  calc_end, calc_slice_size,
      output slice_valid, slice_column, slice_height,
      input  slice_ready
   );

   modport slave (
      input  calc_playerX, calc_playerY,
      input  calc_angle_X, calc_angle_Y,
      input  calc_column, calc_begin,
      output calc_end, calc_slice_size,
      input  slice_valid, slice_column, slice_height,
      output slice_ready
   );

endinterface

// File: rtl/column_slice_scheduler_out.sv
// One-entry valid/ready holding register for (column, height) results.
// A full register may be reloaded in the same cycle it is drained.
module slice_out_reg
   import raycast_pkg::COL_W;
#(
   parameter int HEIGHT_W = raycast_pkg::HEIGHT_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic [COL_W-1:0]    load_column,
   input  logic [HEIGHT_W-1:0] load_height,
   input  logic                ready,
   output logic                can_load,
   output logic                valid,
   output logic [COL_W-1:0]    column,
   output logic [HEIGHT_W-1:0] height
);

   assign can_load = !valid || ready;

   // Hold the result until the drawer takes it; reload wins over drain.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid  <= 1'b0;
         column <= '0;
         height <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         column <= load_column;
         height <= load_height;
      end else if (ready) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/column_slice_scheduler.sv
// Frame sequencer: latches the pose, walks every screen column through
// the slice calculator and hands each result to the column drawer.
module column_slice_scheduler
   import raycast_pkg::sched_state_t, raycast_pkg::IDLE,
          raycast_pkg::ISSUE, raycast_pkg::WAIT_CALC,
          raycast_pkg::PUSH, raycast_pkg::DONE,
          raycast_pkg::COORD_W, raycast_pkg::ANGLE_W,
          raycast_pkg::COL_W;
#(
   parameter int NUM_COLUMNS = raycast_pkg::NUM_COLUMNS,
   parameter int TIMEOUT     = 255,
   parameter int HEIGHT_W    = raycast_pkg::HEIGHT_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start_frame,
   input  logic signed [COORD_W-1:0] playerX,
   input  logic signed [COORD_W-1:0] playerY,
   input  logic signed [ANGLE_W-1:0] angle_X,
   input  logic signed [ANGLE_W-1:0] angle_Y,
   column_slice_scheduler_if.master  bus,
   output logic                      frame_busy,
   output logic                      frame_done,
   output logic                      timeout_seen
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLUMNS - 1);

   sched_state_t        state;
   sched_state_t        state_nxt;
   logic [CNT_W-1:0]    wait_cnt;
   logic [HEIGHT_W-1:0] result;
   logic                load;
   logic                can_load;
   logic                tmo_hit;
   logic                last_col;

   // Timeout fires on the cycle the counter would reach TIMEOUT.
   assign tmo_hit  = (wait_cnt == CNT_LAST);
   assign last_col = (bus.calc_column == COL_LAST);

   assign bus.calc_begin = (state == ISSUE);
   assign frame_busy     = (state != IDLE);
   assign frame_done     = (state == DONE);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and output-register load decision.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      unique case (state)
         IDLE:
            if (start_frame) state_nxt = ISSUE;
         ISSUE:
            state_nxt = WAIT_CALC;
         WAIT_CALC:
            if (bus.calc_end || tmo_hit) state_nxt = PUSH;
         PUSH:
            if (can_load) begin
               load      = 1'b1;
               state_nxt = last_col ? DONE : ISSUE;
            end
         DONE:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   // Pose latch, column walk, wait counter and result capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.calc_playerX <= '0;
         bus.calc_playerY <= '0;
         bus.calc_angle_X <= '0;
         bus.calc_angle_Y <= '0;
         bus.calc_column  <= '0;
         wait_cnt         <= '0;
         result           <= '0;
         timeout_seen     <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (start_frame) begin
                  bus.calc_playerX <= playerX;
                  bus.calc_playerY <= playerY;
                  bus.calc_angle_X <= angle_X;
                  bus.calc_angle_Y <= angle_Y;
                  bus.calc_column  <= '0;
                  timeout_seen     <= 1'b0;
               end
            ISSUE:
               wait_cnt <= '0;
            WAIT_CALC: begin
               if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
               if (bus.calc_end) begin
                  result <= bus.calc_slice_size;
               end else if (tmo_hit) begin
                  result       <= '0;
                  timeout_seen <= 1'b1;
               end
            end
            PUSH:
               if (load && !last_col)
                  bus.calc_column <= bus.calc_column + 1'b1;
            default: ;
         endcase
      end
   end

   slice_out_reg #(
      .HEIGHT_W (HEIGHT_W)
   ) u_out (
      .clock       (clock),
      .reset       (reset),
      .load        (load),
      .load_column (bus.calc_column),
      .load_height (result),
      .ready       (bus.slice_ready),
      .can_load    (can_load),
      .valid       (bus.slice_valid),
      .column      (bus.slice_column),
      .height      (bus.slice_height)
   );

endmodule
